program_sequencer: RTL
======================

// Module: program_sequencer
// PURPOSE
//  Parametrised next-generation program counter. Adds configurable width, step, branch
//  shift and reset vector, plus a circular return-address stack (RAS) for call/return.
//  Sits between the control unit (drives ps/in/stall) and instruction memory (reads pc).
// PARAMETERS
//  W          64   datapath/address width (bits)
//  STEP       4    sequential increment added to pc
//  SHIFT      2    left shift applied to relative offsets (in << SHIFT)
//  RESET_VEC  0    pc value loaded on reset (W bits)
//  RAS_DEPTH  8    return-address stack entries (power of 2, >= 2)
// PORTS
//  clock      in   1                    rising-edge clock
//  reset      in   1                    synchronous, active-high
//  ps         in   3                    pc function select (see BEHAVIOUR)
//  in         in   W                    absolute target or signed offset
//  stall      in   1                    1 = freeze pc and RAS this cycle
//  pc         out  W                    current program counter (registered)
//  pc_seq     out  W                    pc + STEP (combinational)
//  ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries
//  ras_empty  out  1                    ras_count == 0
//  ras_full   out  1                    ras_count == RAS_DEPTH
//  ras_ovf    out  1                    1-cycle pulse: push while full
//  ras_unf    out  1                    1-cycle pulse: pop while empty
// BEHAVIOUR
//  - Reset (sampled on clock edge): pc<=RESET_VEC, ras_count<=0, top ptr<=0, pulses<=0.
//    Reset overrides stall and ps; RAS contents need not be cleared.
//  - All arithmetic is modulo 2^W; offset = in << SHIFT (low bits zero, upper bits dropped).
//  - ps decode, applied on the edge when stall=0 (1-cycle latency, new pc visible next cycle):
//    000 HOLD  pc<=pc
//    001 SEQ   pc<=pc+STEP
//    010 JMP   pc<=in
//    011 BR    pc<=pc+offset
//    100 CALL  push pc+STEP; pc<=in
//    101 CALLR push pc+STEP; pc<=pc+offset
//    110 RET   pop top; pc<=popped value
//    111 rsvd  same as SEQ; no RAS effect
//  - stall=1: pc, RAS, ras_count unchanged; ras_ovf/ras_unf driven 0.
//  - RAS is circular: push writes entry[ptr], ptr<=ptr+1 (wraps at RAS_DEPTH);
//    pop reads entry[ptr-1], ptr<=ptr-1.
//  - Push when full: write proceeds, overwriting the oldest entry; ras_count stays
//    RAS_DEPTH; ras_ovf=1 for one cycle.
//  - Pop when empty: pc<=in (fallback target supplied by control), ptr and count
//    unchanged; ras_unf=1 for one cycle.
//  - Normal push: count+1; normal pop: count-1. Only one RAS operation per cycle.
//  - ras_ovf/ras_unf are registered pulses, valid the cycle after the offending op.
//  - pc_seq follows pc combinationally; it is never registered separately.
// TESTING
//  1 reset=1 two cycles, then ps=001 x3 -> pc 0,4,8,12; ras_empty=1.
//  2 pc=0x100, ps=011, in=0xFFFF...FFFE -> pc=0xF8 (signed -2<<2, wraps mod 2^W).
//  3 pc=0x40, ps=100, in=0x800 -> pc=0x800, ras_count=1; then ps=110 ->
//    pc=0x44, ras_empty=1.
//  4 nine CALLs (DEPTH=8) with return addrs A1..A9 -> ras_ovf pulse on 9th,
//    count=8; eight RETs -> pc=A9..A2; ninth RET with in=0x200 -> pc=0x200, ras_unf=1.
//  5 ps=100 with stall=1 for 3 cycles -> pc and ras_count unchanged, no pulses;
//    stall drops -> call executes once.
//  6 reset asserted mid-sequence with ras_count=3, ps=110 -> next pc=RESET_VEC,
//    ras_count=0, no pop.

Source files
------------

// File: rtl/program_sequencer_if.sv
// Bundle between the control unit and the program sequencer: the control unit drives
// the pc function select, the operand and stall, and receives the pc and RAS status.
interface program_sequencer_if #(
  parameter int W         = 64,
  parameter int RAS_DEPTH = 8
);
  localparam int CW = $clog2(RAS_DEPTH) + 1;

  logic [2:0]    ps;
  logic [W-1:0]  in;
  logic          stall;
  logic [W-1:0]  pc;
  logic [W-1:0]  pc_seq;
  logic [CW-1:0] ras_count;
  logic          ras_empty;
  logic          ras_full;
  logic          ras_ovf;
  logic          ras_unf;

  modport master (
    output ps, in, stall,
    input  pc, pc_seq, ras_count, ras_empty, ras_full, ras_ovf, ras_unf
  );

  modport slave (
    input  ps, in, stall,
    output pc, pc_seq, ras_count, ras_empty, ras_full, ras_ovf, ras_unf
  );
endinterface

// File: rtl/program_sequencer.sv
// Program counter with sequential/jump/branch/call/return functions and a circular
// return-address stack that overwrites its oldest entry on overflow.
module program_sequencer #(
  parameter int             W         = 64,
  parameter int             STEP      = 4,
  parameter int             SHIFT     = 2,
  parameter logic [W-1:0]   RESET_VEC = '0,
  parameter int             RAS_DEPTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  program_sequencer_if.slave   bus
);
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CW    = PTR_W + 1;
  localparam logic [W-1:0]  STEP_W  = W'(STEP);
  localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

  logic [W-1:0]     pc_reg, pc_next;
  logic [W-1:0]     pc_seq;
  logic [W-1:0]     offset;
  logic [W-1:0]     ras_top;
  logic [PTR_W-1:0] ptr_reg, ptr_next;
  logic [CW-1:0]    count_reg, count_next;
  logic             ovf_reg, ovf_next;
  logic             unf_reg, unf_next;
  logic             push;
  logic             ras_empty, ras_full;
  logic [W-1:0]     ras_mem [RAS_DEPTH];

  assign pc_seq    = pc_reg + STEP_W;
  assign offset    = bus.in << SHIFT;
  assign ras_top   = ras_mem[ptr_reg - PTR_W'(1)];
  assign ras_empty = (count_reg == '0);
  assign ras_full  = (count_reg == DEPTH_C);

  always_comb begin
    pc_next    = pc_reg;
    ptr_next   = ptr_reg;
    count_next = count_reg;
    ovf_next   = 1'b0;
    unf_next   = 1'b0;
    push       = 1'b0;
    if (!bus.stall) begin
      unique case (bus.ps)
        3'b000: begin
          pc_next = pc_reg;
        end
        3'b001, 3'b111: begin
          pc_next = pc_seq;
        end
        3'b010: begin
          pc_next = bus.in;
        end
        3'b011: begin
          pc_next = pc_reg + offset;
        end
        3'b100, 3'b101: begin
          push     = 1'b1;
          pc_next  = bus.ps[0] ? (pc_reg + offset) : bus.in;
          ptr_next = ptr_reg + PTR_W'(1);
          // A full stack keeps its count; the write lands on the oldest slot.
          if (ras_full) ovf_next = 1'b1;
          else          count_next = count_reg + CW'(1);
        end
        3'b110: begin
          if (ras_empty) begin
            pc_next  = bus.in;
            unf_next = 1'b1;
          end else begin
            pc_next    = ras_top;
            ptr_next   = ptr_reg - PTR_W'(1);
            count_next = count_reg - CW'(1);
          end
        end
        default: begin
          pc_next = pc_seq;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_reg    <= RESET_VEC;
      ptr_reg   <= '0;
      count_reg <= '0;
      ovf_reg   <= 1'b0;
      unf_reg   <= 1'b0;
    end else begin
      pc_reg    <= pc_next;
      ptr_reg   <= ptr_next;
      count_reg <= count_next;
      ovf_reg   <= ovf_next;
      unf_reg   <= unf_next;
    end
  end

  // Stack storage needs no reset; only the pointer and count define validity.
  always_ff @(posedge clock) begin
    if (!reset && push) ras_mem[ptr_reg] <= pc_seq;
  end

  assign bus.pc        = pc_reg;
  assign bus.pc_seq    = pc_seq;
  assign bus.ras_count = count_reg;
  assign bus.ras_empty = ras_empty;
  assign bus.ras_full  = ras_full;
  assign bus.ras_ovf   = ovf_reg;
  assign bus.ras_unf   = unf_reg;
endmodule
